// File: rtl/db_qp_line_buf.sv
// Simple-dual-port line buffer holding deblocking QP/flag words, one per CU column.
// Per-bit masked writes, same-cycle write-to-read forwarding, optional output register and a frame-start clear engine.
`timescale 1ns/1ps
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module db_qp_line_buf #(
  parameter int                    WORD_WIDTH  = 20,
  parameter int                    ADDR_WIDTH  = `PIC_X_WIDTH,
  parameter int                    DEPTH       = 1 << ADDR_WIDTH,
  parameter int                    OUT_REG     = 0,
  parameter logic [WORD_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_mask_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  dbg_state_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Handshake: a port request is taken in any cycle its enable is high while the FSM is IDLE;
  // there is no back-pressure, and each accepted read produces exactly one rd_valid_o pulse.

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_done, w_done_nxt;

  logic                  w_idle;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rd_in_range;
  logic                  w_fwd;
  logic [WORD_WIDTH-1:0] w_rd_word;

  logic                  r_s1_valid;
  logic [WORD_WIDTH-1:0] r_s1_data;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_wr_acc      = wr_en_i && w_idle && ({1'b0, wr_addr_i} < LP_DEPTH);
  assign w_rd_acc      = rd_en_i && w_idle;
  assign w_rd_in_range = ({1'b0, rd_addr_i} < LP_DEPTH);
  assign w_fwd         = w_wr_acc && (wr_addr_i == rd_addr_i);

  // Forwarded word is the merge the write is about to commit, so a read never sees stale fields.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (w_fwd) begin
        w_rd_word = (r_mem[rd_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
      end else begin
        w_rd_word = r_mem[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= CLEAR_VALUE;
    end else if (w_wr_acc) begin
      for (int b = 0; b < WORD_WIDTH; b++) begin
        if (wr_mask_i[b]) r_mem[wr_addr_i][b] <= wr_data_i[b];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_start_i) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // Terminate on the last index rather than wrap so DEPTH == 2^ADDR_WIDTH works too.
        if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_data <= w_rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  r_s2_valid;
      logic [WORD_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2_data <= r_s1_data;
        end
      end

      assign rd_valid_o = r_s2_valid;
      assign rd_data_o  = r_s2_data;
    end else begin : g_noreg
      assign rd_valid_o = r_s1_valid;
      assign rd_data_o  = r_s1_data;
    end
  endgenerate

  assign clr_busy_o  = (r_state == ST_CLEAR);
  assign clr_done_o  = r_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_db_qp_line_buf.sv
// Bench for db_qp_line_buf: DUT0 is DEPTH=16/OUT_REG=0, DUT1 is DEPTH=12/OUT_REG=1.
// Read results go through an expected queue per DUT and are checked by a negedge monitor.
`timescale 1ns/1ps

module tb_db_qp_line_buf;

  localparam int AW = 4;
  localparam int W  = 20;
  localparam logic [W-1:0] CV = 20'h00FFF;

  typedef struct packed {
    logic [W-1:0] data;
    logic [31:0]  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          clr_start [2];
  logic          wr_en     [2];
  logic [AW-1:0] wr_addr   [2];
  logic [W-1:0]  wr_mask   [2];
  logic [W-1:0]  wr_data   [2];
  logic          rd_en     [2];
  logic [AW-1:0] rd_addr   [2];
  logic [W-1:0]  rd_data   [2];
  logic          rd_valid  [2];
  logic          clr_busy  [2];
  logic          clr_done  [2];
  logic          dbg_state [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  db_qp_line_buf #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(16), .OUT_REG(0), .CLEAR_VALUE(CV)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr_start_i(clr_start[0]), .clr_busy_o(clr_busy[0]),
    .clr_done_o(clr_done[0]), .wr_en_i(wr_en[0]), .wr_addr_i(wr_addr[0]), .wr_mask_i(wr_mask[0]),
    .wr_data_i(wr_data[0]), .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr[0]), .rd_data_o(rd_data[0]),
    .rd_valid_o(rd_valid[0]), .dbg_state_o(dbg_state[0]));

  db_qp_line_buf #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(12), .OUT_REG(1), .CLEAR_VALUE(CV)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr_start_i(clr_start[1]), .clr_busy_o(clr_busy[1]),
    .clr_done_o(clr_done[1]), .wr_en_i(wr_en[1]), .wr_addr_i(wr_addr[1]), .wr_mask_i(wr_mask[1]),
    .wr_data_i(wr_data[1]), .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr[1]), .rd_data_o(rd_data[1]),
    .rd_valid_o(rd_valid[1]), .dbg_state_o(dbg_state[1]));

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic mon_match(input int d, input exp_t e);
    chk($sformatf("rd_data_dut%0d", d), 32'(rd_data[d]), 32'(e.data));
    chk($sformatf("rd_cycle_dut%0d", d), 32'(cyc), e.cyc);
  endtask

  task automatic mon_missing(input int d, input exp_t e);
    n_cmp++;
    n_fail++;
    $display("FAIL rd_missing_dut%0d: actual no rd_valid_o by cycle %0d, required data %h at cycle %0d",
             d, cyc, e.data, e.cyc);
  endtask

  task automatic mon_unexpected(input int d);
    n_cmp++;
    n_fail++;
    $display("FAIL rd_unexpected_dut%0d: actual rd_valid_o=1 data %h at cycle %0d, required rd_valid_o=0",
             d, rd_data[d], cyc);
  endtask

  // ---------------- scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q0.size() > 0 && exp_q0[0].cyc < 32'(cyc)) mon_missing(0, exp_q0.pop_front());
      if (rd_valid[0]) begin
        if (exp_q0.size() == 0) mon_unexpected(0);
        else mon_match(0, exp_q0.pop_front());
      end
      if (exp_q1.size() > 0 && exp_q1[0].cyc < 32'(cyc)) mon_missing(1, exp_q1.pop_front());
      if (rd_valid[1]) begin
        if (exp_q1.size() == 0) mon_unexpected(1);
        else mon_match(1, exp_q1.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called just after a posedge)
  task automatic clr_in(input int d);
    clr_start[d] = 1'b0;
    wr_en[d]     = 1'b0;
    wr_addr[d]   = '0;
    wr_mask[d]   = '0;
    wr_data[d]   = '0;
    rd_en[d]     = 1'b0;
    rd_addr[d]   = '0;
  endtask

  task automatic op(input int d, input bit cs, input bit we, input logic [AW-1:0] wa,
                    input logic [W-1:0] wm, input logic [W-1:0] wd, input bit re,
                    input logic [AW-1:0] ra, input bit push, input logic [W-1:0] rexp);
    exp_t e;
    clr_start[d] = cs;
    wr_en[d]     = we;
    wr_addr[d]   = wa;
    wr_mask[d]   = wm;
    wr_data[d]   = wd;
    rd_en[d]     = re;
    rd_addr[d]   = ra;
    if (push) begin
      e.data = rexp;
      e.cyc  = 32'(cyc + 1 + d);
      if (d == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    @(posedge clk);
    #1;
    clr_in(d);
  endtask

  task automatic wr(input int d, input logic [AW-1:0] a, input logic [W-1:0] m, input logic [W-1:0] v);
    op(d, 1'b0, 1'b1, a, m, v, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] a, input logic [W-1:0] x);
    op(d, 1'b0, 1'b0, '0, '0, '0, 1'b1, a, 1'b1, x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses clr_start (optionally with a read in the same cycle) and watches busy/done for a bounded window.
  task automatic clear_watch(input int d, input int exp_len, input bit poke, input bit sr,
                             input logic [AW-1:0] sra, input logic [W-1:0] srx);
    int busy_n = 0;
    int done_n = 0;
    int last_busy = -1;
    int done_at = -2;
    op(d, 1'b1, 1'b0, '0, '0, '0, sr, sra, sr, srx);
    for (int i = 0; i < exp_len + 6; i++) begin
      if (clr_busy[d]) begin
        busy_n++;
        last_busy = i;
      end
      if (clr_done[d]) begin
        done_n++;
        done_at = i;
      end
      if (clr_busy[d] && poke)
        op(d, (i % 4 == 1), 1'b1, AW'(i + 15), '1, 20'h55555, 1'b1, AW'(i), 1'b0, '0);
      else
        idle(1);
    end
    chk($sformatf("clr_busy_cycles_dut%0d", d), 32'(busy_n), 32'(exp_len));
    chk($sformatf("clr_done_pulses_dut%0d", d), 32'(done_n), 32'd1);
    chk($sformatf("clr_done_position_dut%0d", d), 32'(done_at), 32'(last_busy + 1));
  endtask

  // ---------------- directed sequence
  initial begin
    int done_seen;
    clr_in(0);
    clr_in(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rd_data_dut%0d", d), 32'(rd_data[d]), 32'd0);
      chk($sformatf("rst_rd_valid_dut%0d", d), 32'(rd_valid[d]), 32'd0);
      chk($sformatf("rst_clr_busy_dut%0d", d), 32'(clr_busy[d]), 32'd0);
      chk($sformatf("rst_clr_done_dut%0d", d), 32'(clr_done[d]), 32'd0);
      chk($sformatf("rst_state_dut%0d", d), 32'(dbg_state[d]), 32'd0);
    end
    rst_n = 1'b1;
    idle(1);

    // Masked writes and latency on both output configurations
    for (int d = 0; d < 2; d++) begin
      wr(d, 4'd5, 20'hFFFFF, 20'h00000);
      wr(d, 4'd5, 20'h0003F, 20'hFFFFF);
      rd(d, 4'd5, 20'h0003F);
      wr(d, 4'd5, 20'h00FC0, 20'h00000);
      rd(d, 4'd5, 20'h0003F);
    end

    // Same-cycle forwarding, then a plain re-read
    for (int d = 0; d < 2; d++) begin
      wr(d, 4'd9, 20'hFFFFF, 20'h12345);
      op(d, 1'b0, 1'b1, 4'd9, 20'hFF000, 20'hABCDE, 1'b1, 4'd9, 1'b1, 20'hAB345);
      rd(d, 4'd9, 20'hAB345);
    end
    idle(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("hold_rd_data_dut%0d", d), 32'(rd_data[d]), 32'h000AB345);
      chk($sformatf("hold_rd_valid_dut%0d", d), 32'(rd_valid[d]), 32'd0);
    end

    // Clear with reads/writes/restarts poked throughout; read in the start cycle completes
    clear_watch(0, 16, 1'b1, 1'b1, 4'd9, 20'hAB345);
    for (int a = 0; a < 16; a++) rd(0, AW'(a), CV);
    idle(2);

    // Reset in the middle of a clear
    for (int a = 0; a < 16; a++) wr(0, AW'(a), 20'hFFFFF, 20'h22222);
    op(0, 1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    idle(7);
    chk("midclr_busy_before_reset", 32'(clr_busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_busy", 32'(clr_busy[0]), 32'd0);
    chk("midclr_rst_done", 32'(clr_done[0]), 32'd0);
    chk("midclr_rst_valid", 32'(rd_valid[0]), 32'd0);
    chk("midclr_rst_data", 32'(rd_data[0]), 32'd0);
    chk("midclr_rst_state", 32'(dbg_state[0]), 32'd0);
    idle(2);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_done[0]) done_seen++;
      idle(1);
    end
    chk("midclr_no_done_pulse", 32'(done_seen), 32'd0);
    rd(0, 4'd6, CV);
    rd(0, 4'd7, 20'h22222);
    clear_watch(0, 16, 1'b0, 1'b0, '0, '0);
    rd(0, 4'd7, CV);
    rd(0, 4'd15, CV);

    // DEPTH=12 boundary: out-of-range write dropped, out-of-range read returns 0
    clear_watch(1, 12, 1'b0, 1'b0, '0, '0);
    wr(1, 4'd13, 20'hFFFFF, 20'h33333);
    rd(1, 4'd13, 20'h00000);
    for (int a = 0; a < 12; a++) rd(1, AW'(a), CV);

    idle(4);
    chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
